// File: rtl/neural_spike_detector_if.sv
// Sample-stream and event-stream bundle for neural_spike_detector.
// slave is the detector side; master is the sample source and event consumer.
interface neural_spike_detector_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CH_ID_WIDTH = 4,
    parameter int FIFO_DEPTH  = 8
);
    logic signed [DATA_WIDTH-1:0] adc_data_in;
    logic [CH_ID_WIDTH-1:0]       adc_channel_in;
    logic                         adc_valid_in;
    logic [DATA_WIDTH-1:0]        thresh_in;
    logic                         enable;
    logic                         evt_valid;
    logic                         evt_ready;
    logic [CH_ID_WIDTH-1:0]       evt_channel;
    logic signed [DATA_WIDTH:0]   evt_amplitude;
    logic [15:0]                  evt_timestamp;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic [7:0]                   overflow_count;

    modport master (
        output adc_data_in, adc_channel_in, adc_valid_in, thresh_in, enable, evt_ready,
        input  evt_valid, evt_channel, evt_amplitude, evt_timestamp, fifo_level, overflow_count
    );

    modport slave (
        input  adc_data_in, adc_channel_in, adc_valid_in, thresh_in, enable, evt_ready,
        output evt_valid, evt_channel, evt_amplitude, evt_timestamp, fifo_level, overflow_count
    );
endinterface

// File: rtl/neural_spike_detector.sv
// Per-channel IIR-baseline spike detector with refractory hold-off and a
// first-word-fall-through event FIFO; two stages: input register, then compute/update/push.
module neural_spike_detector #(
    parameter int NUM_CHANNELS    = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int CH_ID_WIDTH     = 4,
    parameter int BASE_SHIFT      = 4,
    parameter int REFRACT_SAMPLES = 8,
    parameter int FIFO_DEPTH      = 8
) (
    input logic                    sys_clk,
    input logic                    rst_n,
    neural_spike_detector_if.slave bus
);
    localparam int AMP_W = DATA_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = CH_ID_WIDTH + AMP_W + 16;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    function automatic logic [AMP_W-1:0] abs_dev(input logic signed [AMP_W-1:0] d);
        return d[AMP_W-1] ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic                         r_vld_p1;
    logic signed [DATA_WIDTH-1:0] r_data_p1;
    logic [CH_ID_WIDTH-1:0]       r_ch_p1;
    logic                         r_en_p1;
    logic [DATA_WIDTH-1:0]        r_thr_p1;

    logic signed [DATA_WIDTH-1:0] r_base   [NUM_CHANNELS];
    logic                         r_primed [NUM_CHANNELS];
    logic [7:0]                   r_refr   [NUM_CHANNELS];
    logic [15:0]                  r_frame;

    logic [ENT_W-1:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr;
    logic [PTR_W-1:0]             r_rd;
    logic [LVL_W-1:0]             r_count;
    logic [7:0]                   r_ovf;

    logic                         w_ch_ok;
    logic                         w_primed;
    logic [7:0]                   w_refr;
    logic signed [DATA_WIDTH-1:0] w_base;
    logic signed [DATA_WIDTH-1:0] w_base_next;
    logic signed [AMP_W-1:0]      w_dev;
    logic signed [AMP_W-1:0]      w_step;
    logic [AMP_W-1:0]             w_abs;
    logic                         w_detect;
    logic [15:0]                  w_stamp;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_push;
    logic                         w_drop;
    logic [ENT_W-1:0]             w_head;

    // Stage 1: register the incoming sample together with its enable/threshold context
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_ch_p1   <= '0;
            r_en_p1   <= 1'b0;
            r_thr_p1  <= '0;
        end else begin
            r_vld_p1  <= bus.adc_valid_in;
            r_data_p1 <= bus.adc_data_in;
            r_ch_p1   <= bus.adc_channel_in;
            r_en_p1   <= bus.enable;
            r_thr_p1  <= bus.thresh_in;
        end
    end

    // Stage 2: state arrays are read and written in the same cycle, so a
    // same-channel sample in the next cycle always sees the updated state
    assign w_ch_ok     = r_vld_p1 && (int'(r_ch_p1) < NUM_CHANNELS);
    assign w_base      = r_base[r_ch_p1];
    assign w_primed    = r_primed[r_ch_p1];
    assign w_refr      = r_refr[r_ch_p1];
    assign w_dev       = $signed({r_data_p1[DATA_WIDTH-1], r_data_p1})
                       - $signed({w_base[DATA_WIDTH-1], w_base});
    assign w_step      = w_dev >>> BASE_SHIFT;
    assign w_base_next = DATA_WIDTH'($signed({w_base[DATA_WIDTH-1], w_base}) + w_step);
    assign w_abs       = abs_dev(w_dev);
    assign w_detect    = w_ch_ok && r_en_p1 && w_primed && (w_refr == 8'd0)
                       && (w_abs > {1'b0, r_thr_p1});
    assign w_stamp     = (r_ch_p1 == '0) ? r_frame + 16'd1 : r_frame;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_frame <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_base[i]   <= '0;
                r_primed[i] <= 1'b0;
                r_refr[i]   <= '0;
            end
        end else if (w_ch_ok) begin
            r_frame <= w_stamp;
            if (!w_primed) begin
                r_base[r_ch_p1]   <= r_data_p1;
                r_primed[r_ch_p1] <= 1'b1;
            end else begin
                r_base[r_ch_p1] <= w_base_next;
            end
            if (w_detect) begin
                r_refr[r_ch_p1] <= 8'(REFRACT_SAMPLES);
            end else if (w_refr != 8'd0) begin
                r_refr[r_ch_p1] <= w_refr - 8'd1;
            end
        end
    end

    // A push into a full FIFO is only dropped when no pop frees a slot that cycle
    assign w_pop  = (r_count != '0) && bus.evt_ready;
    assign w_full = (r_count == FULL_LVL);
    assign w_push = w_detect && (!w_full || w_pop);
    assign w_drop = w_detect && w_full && !w_pop;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {r_ch_p1, w_dev, w_stamp};
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LVL_W'(1);
            end
            if (w_drop) begin
                r_ovf <= sat_inc8(r_ovf);
            end
        end
    end

    assign w_head             = (r_count != '0) ? r_mem[r_rd] : '0;
    assign bus.evt_valid      = (r_count != '0);
    assign bus.evt_channel    = w_head[ENT_W-1 -: CH_ID_WIDTH];
    assign bus.evt_amplitude  = w_head[16 +: AMP_W];
    assign bus.evt_timestamp  = w_head[15:0];
    assign bus.fifo_level     = r_count;
    assign bus.overflow_count = r_ovf;
endmodule

// File: doc/neural_spike_detector.md
# neural_spike_detector

Per-channel spike detector on the sys_clk side, directly downstream of the 16-channel TDM aggregator. It consumes the time-multiplexed sample stream (data, channel ID, valid) and keeps a running baseline for each channel. It flags threshold crossings, applies a per-channel refractory hold-off, and queues spike events in a small FIFO for a valid/ready consumer.

## Interface
- NUM_CHANNELS, 16: number of multiplexed channels
- DATA_WIDTH, 16: sample width, signed two's complement
- CH_ID_WIDTH, 4: channel ID width
- BASE_SHIFT, 4: baseline IIR shift (alpha = 2^-BASE_SHIFT)
- REFRACT_SAMPLES, 8: same-channel samples suppressed after an event (1..255)
- FIFO_DEPTH, 8: event FIFO entries (power of 2, >= 2)

Ports:
- sys_clk  in  1  sole clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- adc_data_in  in  DATA_WIDTH  sample (signed)
- adc_channel_in  in  CH_ID_WIDTH  channel ID of sample
- adc_valid_in  in  1  sample strobe; no backpressure, every strobe is consumed
- thresh_in  in  DATA_WIDTH  unsigned detection magnitude, quasi-static
- enable  in  1  detection enable
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accept
- evt_channel  out  CH_ID_WIDTH  channel of head event
- evt_amplitude  out  DATA_WIDTH+1  signed deviation (sample - baseline) of head event
- evt_timestamp  out  16  frame count of head event
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow_count  out  8  dropped events, saturating

## Operation
- Per-channel state is held in flop arrays: baseline[ch] (signed DATA_WIDTH), primed[ch], refr[ch] (8 bits).
- Stage 1 registers the input. Stage 2 computes against the state arrays, writes state back, and pushes to the FIFO.
- Channel IDs >= NUM_CHANNELS are ignored: no state change and no frame increment.
- Frame counter: 16 bits. It increments on each valid sample with channel 0 and wraps 0xFFFF->0. An event carries the post-increment value, so channel 0 in the first frame stamps 1.
- Unprimed channel: baseline <= sample, primed <= 1, no detection.
- Primed channel:
  - dev = sample - baseline, computed at DATA_WIDTH+1 signed.
  - baseline <= baseline + (dev >>> BASE_SHIFT), arithmetic shift. The result stays between baseline and sample, so there is no overflow.
- Detect when all of the following hold: enable=1, primed, refr[ch]==0, and |dev| > thresh_in. |dev| is an unsigned DATA_WIDTH+1 value; thresh_in is zero-extended; the comparison is strict.
- On detect: push {ch, dev, frame}, and refr[ch] <= REFRACT_SAMPLES.
- Otherwise, if refr[ch] != 0: refr[ch] decrements once per sample of that channel.
- Baseline tracking continues while enable=0 and during refractory.
- Back-to-back samples on the same channel: the second sample must see the state written by the first. No stale reads.
- FIFO is first-word fall-through.
  - Pop when evt_valid & evt_ready.
  - Push when full with no pop in the same cycle: event is dropped and overflow_count increments, saturating at 255. refr is still armed.
  - Push when full with a pop in the same cycle: accepted, fifo_level unchanged.
- Reset mid-operation: all state, FIFO contents, and counters are cleared. The in-flight stage-1 sample is discarded.

## Timing
- Reset values: evt_valid=0, evt_channel=0, evt_amplitude=0, evt_timestamp=0, fifo_level=0, overflow_count=0. Frame counter=0, all baselines=0, primed=0, refr=0.
- Latency: input valid in cycle T, event pushed at the end of T+1, evt_valid=1 in T+2 (FIFO previously empty).
- Full throughput: one sample per cycle, sustained.
- evt_* outputs hold stable while evt_valid=1 and evt_ready=0.
- fifo_level updates the cycle after a push or pop.

## Test plan
- Reset: assert rst_n=0 for 2 cycles mid-stream -> all outputs 0; the next sample on any channel only primes, with no event.
- Priming and tracking: ch3 = 1000 then 1050, thresh=100 -> no events; baseline[3] = 1003 (50>>>4 = 3).
- Positive and negative spikes: ch3 baseline 1000, sample 1200 -> evt_channel=3, evt_amplitude=+200, evt_valid two cycles after input. ch5 baseline 1000, sample 800 -> amplitude -200.
- Refractory: ch3 baseline 1000, samples 1200 then nine samples of 1300 -> event on 1200. The next 8 samples are suppressed. The 9th emits amplitude +175 (baseline 1125).
- Backpressure/overflow: evt_ready=0, 10 spikes on distinct primed channels -> fifo_level=8, overflow_count=2. Raising evt_ready drains the first 8 in order. Pushing while full with a same-cycle pop is not counted as a drop.
- Back-to-back same channel, plus timestamp wrap: ch7 at 1000,1200,1200 on consecutive cycles -> one event, amplitude +200, second sample suppressed. Preload the frame counter to 0xFFFF, then a channel-0 spike -> timestamp 0.
